// File: rtl/ntt_stage_sequencer.sv
// ============================================================================
// Module  : ntt_stage_sequencer
// Brief   : Sequences CT/GS butterfly stages over an in-place coefficient RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_stage_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_N      = 8,
    parameter int BU_LATENCY = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  mode_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [LOG_N-1:0]      rd_addr1_o,
    output logic [LOG_N-1:0]      rd_addr2_o,
    output logic [LOG_N-1:0]      zeta_idx_o,
    input  logic [DATA_WIDTH-1:0] rd_data1_i,
    input  logic [DATA_WIDTH-1:0] rd_data2_i,
    input  logic [DATA_WIDTH-1:0] zeta_i,
    output logic                  bu_valid_o,
    output logic [DATA_WIDTH-1:0] bu_rs1_o,
    output logic [DATA_WIDTH-1:0] bu_rs2_o,
    output logic [DATA_WIDTH-1:0] bu_w_o,
    input  logic [DATA_WIDTH-1:0] bu_rs1_i,
    input  logic [DATA_WIDTH-1:0] bu_rs2_i,
    output logic                  wr_en_o,
    output logic [LOG_N-1:0]      wr_addr1_o,
    output logic [LOG_N-1:0]      wr_addr2_o,
    output logic [DATA_WIDTH-1:0] wr_data1_o,
    output logic [DATA_WIDTH-1:0] wr_data2_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [LOG_N-1:0] c_one  = LOG_N'(1);
    localparam logic [LOG_N-1:0] c_last = LOG_N'(LOG_N - 1);
    localparam logic [LOG_N-1:0] c_half = LOG_N'(1) << (LOG_N - 1);

    state_t           state_q;
    logic [LOG_N-1:0] s_q;
    logic [LOG_N-1:0] j_q;
    logic             mode_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic [LOG_N-1:0] rd_addr1_q;
    logic [LOG_N-1:0] rd_addr2_q;
    logic [LOG_N-1:0] zeta_idx_q;

    logic [BU_LATENCY:0]            vld_pipe_q;
    logic [BU_LATENCY:0][LOG_N-1:0] wa1_pipe_q;
    logic [BU_LATENCY:0][LOG_N-1:0] wa2_pipe_q;

    logic [LOG_N-1:0] sel_s;
    logic [LOG_N-1:0] sel_j;
    logic             sel_mode;
    logic [LOG_N-1:0] sh;
    logic [LOG_N-1:0] len;
    logic [LOG_N-1:0] grp;
    logic [LOG_N-1:0] off;
    logic [LOG_N-1:0] addr1_d;
    logic [LOG_N-1:0] addr2_d;
    logic [LOG_N-1:0] zeta_d;
    logic             last_wr;

    // Address of the butterfly about to be issued; sh = log2(len) for both orderings.
    always_comb begin
        sel_s    = '0;
        sel_j    = '0;
        sel_mode = mode_q;
        case (state_q)
            S_IDLE:  sel_mode = mode_i;
            S_ISSUE: begin
                sel_s = s_q;
                sel_j = j_q;
            end
            S_DRAIN: sel_s = s_q + c_one;
            default: sel_s = '0;
        endcase
        sh      = sel_mode ? (c_last - sel_s) : sel_s;
        len     = c_one << sh;
        grp     = sel_j >> sh;
        off     = sel_j & (len - c_one);
        addr1_d = (grp << (sh + c_one)) | off;
        addr2_d = addr1_d | len;
        zeta_d  = (c_one << (c_last - sh)) + grp;
    end

    assign last_wr = vld_pipe_q[BU_LATENCY] && !(|vld_pipe_q[BU_LATENCY-1:0]);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            zeta_idx_q <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q     <= mode_i;
                        s_q        <= '0;
                        j_q        <= c_one;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        rd_addr1_q <= addr1_d;
                        rd_addr2_q <= addr2_d;
                        zeta_idx_q <= zeta_d;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (j_q == c_half) begin
                        state_q <= S_DRAIN;
                    end else begin
                        j_q        <= j_q + c_one;
                        rd_en_q    <= 1'b1;
                        rd_addr1_q <= addr1_d;
                        rd_addr2_q <= addr2_d;
                        zeta_idx_q <= zeta_d;
                    end
                end
                S_DRAIN: begin
                    // Next stage may only read once its producer stage has fully written back.
                    if (last_wr) begin
                        if (s_q == c_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            s_q        <= s_q + c_one;
                            j_q        <= c_one;
                            rd_en_q    <= 1'b1;
                            rd_addr1_q <= addr1_d;
                            rd_addr2_q <= addr2_d;
                            zeta_idx_q <= zeta_d;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            vld_pipe_q <= '0;
            wa1_pipe_q <= '0;
            wa2_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[BU_LATENCY-1:0], rd_en_q};
            wa1_pipe_q <= {wa1_pipe_q[BU_LATENCY-1:0], rd_addr1_q};
            wa2_pipe_q <= {wa2_pipe_q[BU_LATENCY-1:0], rd_addr2_q};
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_en_o    = rd_en_q;
    assign rd_addr1_o = rd_addr1_q;
    assign rd_addr2_o = rd_addr2_q;
    assign zeta_idx_o = zeta_idx_q;
    assign bu_valid_o = vld_pipe_q[0];
    assign bu_rs1_o   = rd_data1_i;
    assign bu_rs2_o   = rd_data2_i;
    assign bu_w_o     = zeta_i;
    assign wr_en_o    = vld_pipe_q[BU_LATENCY];
    assign wr_addr1_o = wa1_pipe_q[BU_LATENCY];
    assign wr_addr2_o = wa2_pipe_q[BU_LATENCY];
    assign wr_data1_o = bu_rs1_i;
    assign wr_data2_o = bu_rs2_i;

endmodule

`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
// ============================================================================
// Module  : tb_ntt_stage_sequencer
// Brief   : Self-checking bench: address tables, cycle timing, NTT/INTT round trip.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ntt_stage_sequencer;

    localparam int DW   = 32;
    localparam int LN   = 3;
    localparam int BUL  = 3;
    localparam int N    = 8;
    localparam int HALF = 4;
    localparam int P    = HALF + BUL + 1;
    localparam int Q    = 17;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          mode;
    logic          busy, done, rd_en, bu_valid, wr_en;
    logic [LN-1:0] rd_addr1, rd_addr2, zeta_idx, wr_addr1, wr_addr2;
    logic [DW-1:0] rd_data1, rd_data2, zeta;
    logic [DW-1:0] bu_rs1_o, bu_rs2_o, bu_w_o, bu_rs1_i, bu_rs2_i;
    logic [DW-1:0] wr_data1, wr_data2;

    always #5 clk = ~clk;

    ntt_stage_sequencer #(.DATA_WIDTH(DW), .LOG_N(LN), .BU_LATENCY(BUL)) dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .mode_i(mode),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
        .rd_addr1_o(rd_addr1), .rd_addr2_o(rd_addr2), .zeta_idx_o(zeta_idx),
        .rd_data1_i(rd_data1), .rd_data2_i(rd_data2), .zeta_i(zeta),
        .bu_valid_o(bu_valid), .bu_rs1_o(bu_rs1_o), .bu_rs2_o(bu_rs2_o), .bu_w_o(bu_w_o),
        .bu_rs1_i(bu_rs1_i), .bu_rs2_i(bu_rs2_i),
        .wr_en_o(wr_en), .wr_addr1_o(wr_addr1), .wr_addr2_o(wr_addr2),
        .wr_data1_o(wr_data1), .wr_data2_o(wr_data2)
    );

    // Environment: coefficient RAM, zeta ROMs (forward / inverse) and a modular butterfly.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] zf [N];
    logic [DW-1:0] zi [N];
    logic [DW-1:0] bp1 [BUL];
    logic [DW-1:0] bp2 [BUL];
    logic          load_en;
    logic [LN-1:0] load_addr;
    logic [DW-1:0] load_data;
    int            orig [N];

    function automatic logic [DW-1:0] bf1(input logic [DW-1:0] a, b, w, input logic m);
        if (m) return (a + (w * b) % Q) % Q;
        return (a + b) % Q;
    endfunction

    function automatic logic [DW-1:0] bf2(input logic [DW-1:0] a, b, w, input logic m);
        if (m) return (a + Q - (w * b) % Q) % Q;
        return (((a + Q - b) % Q) * w) % Q;
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= mem[rd_addr1];
            rd_data2 <= mem[rd_addr2];
            zeta     <= mode ? zf[zeta_idx] : zi[zeta_idx];
        end
        if (load_en) mem[load_addr] <= load_data;
        else if (wr_en) begin
            mem[wr_addr1] <= wr_data1;
            mem[wr_addr2] <= wr_data2;
        end
        for (int k = BUL - 1; k > 0; k--) begin
            bp1[k] <= bp1[k-1];
            bp2[k] <= bp2[k-1];
        end
        bp1[0] <= bf1(bu_rs1_o, bu_rs2_o, bu_w_o, mode);
        bp2[0] <= bf2(bu_rs1_o, bu_rs2_o, bu_w_o, mode);
    end
    assign bu_rs1_i = bp1[BUL-1];
    assign bu_rs2_i = bp2[BUL-1];

    typedef struct {
        logic          md;
        logic [LN-1:0] a1;
        logic [LN-1:0] a2;
        logic [LN-1:0] z;
    } vec_t;

    vec_t tbl [24];
    vec_t rd_q [$];
    vec_t wr_q [$];

    int a1_ct [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int a2_ct [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int z_ct  [12] = '{1, 1, 1, 1,  2, 2, 3, 3,  4, 5, 6, 7};
    int a1_gs [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int a2_gs [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int z_gs  [12] = '{4, 5, 6, 7,  2, 2, 3, 3,  1, 1, 1, 1};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int cy, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle/idx %0d): got %0d, want %0d", nm, cy, act, exp);
        end
    endtask

    function automatic logic in_run(input int c);
        return (c >= 1) && (c <= LN * P);
    endfunction

    function automatic logic exp_rd(input int c);
        return in_run(c) && (((c - 1) % P) < HALF);
    endfunction

    function automatic logic exp_bv(input int c);
        return in_run(c) && (((c - 1) % P) >= 1) && (((c - 1) % P) <= HALF);
    endfunction

    function automatic logic exp_wr(input int c);
        return in_run(c) && (((c - 1) % P) >= BUL + 1) && (((c - 1) % P) <= HALF + BUL);
    endfunction

    task automatic check_idle_outputs(input string tag, input int c);
        chk({tag, "_rd_en"},    c, 32'(rd_en),    0);
        chk({tag, "_bu_valid"}, c, 32'(bu_valid), 0);
        chk({tag, "_wr_en"},    c, 32'(wr_en),    0);
        chk({tag, "_busy"},     c, 32'(busy),     0);
        chk({tag, "_done"},     c, 32'(done),     0);
        chk({tag, "_rd_addr1"}, c, 32'(rd_addr1), 0);
        chk({tag, "_rd_addr2"}, c, 32'(rd_addr2), 0);
        chk({tag, "_zeta_idx"}, c, 32'(zeta_idx), 0);
        chk({tag, "_wr_addr1"}, c, 32'(wr_addr1), 0);
        chk({tag, "_wr_addr2"}, c, 32'(wr_addr2), 0);
    endtask

    // Cycle 0 is the cycle in which start is high; checks land on the falling edge of each cycle.
    task automatic run_xform(input logic m, input int busy_start, input int rst_at);
        int   wr_after;
        int   done_after;
        vec_t v;
        wr_after   = 0;
        done_after = 0;
        foreach (tbl[i]) begin
            if (tbl[i].md == m) begin
                rd_q.push_back(tbl[i]);
                wr_q.push_back(tbl[i]);
            end
        end
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        for (int c = 1; c <= LN * P + 3; c++) begin
            @(negedge clk);
            start = (c == busy_start);
            if (rst_at < 0 || c <= rst_at) begin
                chk("rd_en",    c, 32'(rd_en),    32'(exp_rd(c)));
                chk("bu_valid", c, 32'(bu_valid), 32'(exp_bv(c)));
                chk("wr_en",    c, 32'(wr_en),    32'(exp_wr(c)));
                chk("busy",     c, 32'(busy),     32'(in_run(c)));
                chk("done",     c, 32'(done),     32'(c == LN * P + 1));
                if (rd_en) begin
                    if (rd_q.size() == 0) chk("rd_unexpected", c, 1, 0);
                    else begin
                        v = rd_q.pop_front();
                        chk("rd_addr1", c, 32'(rd_addr1), 32'(v.a1));
                        chk("rd_addr2", c, 32'(rd_addr2), 32'(v.a2));
                        chk("zeta_idx", c, 32'(zeta_idx), 32'(v.z));
                    end
                end
                if (wr_en) begin
                    if (wr_q.size() == 0) chk("wr_unexpected", c, 1, 0);
                    else begin
                        v = wr_q.pop_front();
                        chk("wr_addr1", c, 32'(wr_addr1), 32'(v.a1));
                        chk("wr_addr2", c, 32'(wr_addr2), 32'(v.a2));
                    end
                end
            end
            if (c == rst_at) begin
                reset_n = 1'b0;
                rd_q.delete();
                wr_q.delete();
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                reset_n = 1'b1;
                check_idle_outputs("midrst", c);
            end
            if (rst_at >= 0 && c > rst_at + 1) begin
                if (wr_en) wr_after++;
                if (done)  done_after++;
            end
        end
        if (rst_at < 0) begin
            chk("rd_q_left", 0, 32'(rd_q.size()), 0);
            chk("wr_q_left", 0, 32'(wr_q.size()), 0);
        end else begin
            chk("wr_after_reset",   0, 32'(wr_after),   0);
            chk("done_after_reset", 0, 32'(done_after), 0);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) begin
            orig[i] = int'($urandom_range(0, Q - 1));
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = LN'(i);
            load_data = DW'(orig[i]);
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic check_roundtrip();
        for (int i = 0; i < N; i++) chk("roundtrip", i, mem[i], DW'((N * orig[i]) % Q));
    endtask

    initial begin
        int p;
        reset_n   = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 12; i++) begin
            tbl[i]      = '{1'b1, LN'(a1_ct[i]), LN'(a2_ct[i]), LN'(z_ct[i])};
            tbl[12 + i] = '{1'b0, LN'(a1_gs[i]), LN'(a2_gs[i]), LN'(z_gs[i])};
        end
        p = 1;
        for (int k = 0; k < N; k++) begin
            zf[k] = DW'(p);
            for (int v = 1; v < Q; v++) if ((p * v) % Q == 1) zi[k] = DW'(v);
            p = (p * 3) % Q;
        end

        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 0);
        reset_n = 1'b1;

        load_mem();
        run_xform(1'b1, 10, -1);
        run_xform(1'b0, -1, -1);
        check_roundtrip();

        run_xform(1'b1, -1, 14);

        load_mem();
        run_xform(1'b1, -1, -1);
        run_xform(1'b0, -1, -1);
        check_roundtrip();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
